// File: rtl/sym_fir_tdm.sv
// sym_fir_tdm -- symmetric (linear-phase) FIR filter, time-multiplexed.
//
// One pre-adder, one multiplier and one accumulator are shared across
// HALF=(TAPS+1)/2 cycles per sample. Tap pairs x[k] and x[TAPS-1-k] share
// coefficient h_k, so only HALF coefficients are stored. The coefficients
// are double-buffered. Writes land in a shadow bank. The shadow bank is
// copied into the active bank when a sample is accepted. This means a
// running computation never sees a mix of coefficient sets.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     in_sample is valid this cycle
//   in_sample    signed input sample
//   in_ready     block is idle; a sample is accepted on in_valid && in_ready
//   bypass       sampled at accept; 1 = pass the accepted sample through
//   coef_we      coefficient write strobe (writes the shadow bank)
//   coef_addr    coefficient index k (h_k = h_(TAPS-1-k)); k >= HALF ignored
//   coef_data    signed coefficient value
//   out_valid    one-cycle pulse when out_sample updates
//   out_sample   signed result, held between pulses
//   overrun      sticky flag: in_valid seen while busy; cleared only by rst
//
// Timing: a sample accepted in cycle t produces out_valid in cycle t+HALF+2.
// The block returns to idle in that same cycle, so accepts can be back-to-back.

module sym_fir_tdm #(
  parameter int DATA_W    = 20,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 17,
  parameter int COEF_FRAC = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic signed [DATA_W-1:0]          in_sample,
  output logic                              in_ready,
  input  logic                              bypass,
  input  logic                              coef_we,
  input  logic [$clog2((TAPS+1)/2)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]          coef_data,
  output logic                              out_valid,
  output logic signed [DATA_W-1:0]          out_sample,
  output logic                              overrun
);

  localparam int HALF   = (TAPS + 1) / 2;
  localparam int KW     = $clog2(HALF);
  localparam int TW     = $clog2(TAPS);
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = PROD_W + KW;

  localparam logic signed [ACC_W:0] RND_BIAS = {{ACC_W{1'b0}}, 1'b1} << (COEF_FRAC - 1);
  localparam logic signed [ACC_W:0] SAT_MAX  = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN  = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND} state_t;

  state_t                    state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic signed [DATA_W-1:0]  x_q      [TAPS];
  logic signed [DATA_W-1:0]  x_d      [TAPS];
  logic signed [COEF_W-1:0]  shadow_q [HALF];
  logic signed [COEF_W-1:0]  shadow_d [HALF];
  logic signed [COEF_W-1:0]  active_q [HALF];
  logic signed [COEF_W-1:0]  active_d [HALF];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      byp_q, byp_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  out_sample_q, out_sample_d;
  logic                      overrun_q, overrun_d;

  logic                      accept;
  logic [TW-1:0]             idx_lo, idx_hi;
  logic signed [COEF_W-1:0]  coef_k;
  logic signed [PRE_W-1:0]   pre_add;
  logic signed [PROD_W-1:0]  prod;

  // Round half up: add 2^(COEF_FRAC-1), then shift right arithmetically.
  // One extra bit of headroom keeps the bias add from wrapping.
  function automatic logic signed [ACC_W:0] round_half_up(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] ext;
    ext = {a[ACC_W-1], a} + RND_BIAS;
    return ext >>> COEF_FRAC;
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W:0] v);
    if (v > SAT_MAX)
      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign overrun    = overrun_q;

  // MAC datapath: pre-add the mirrored tap pair, then multiply by h_k.
  // The centre tap has no partner, so it enters the multiplier alone.
  always_comb begin
    idx_lo = TW'(k_q);
    idx_hi = TW'(TAPS - 1) - idx_lo;
    coef_k = active_q[k_q];
    if (k_q == KW'(HALF - 1))
      pre_add = {x_q[idx_lo][DATA_W-1], x_q[idx_lo]};
    else
      pre_add = {x_q[idx_lo][DATA_W-1], x_q[idx_lo]} + {x_q[idx_hi][DATA_W-1], x_q[idx_hi]};
    prod = {{(PROD_W-COEF_W){coef_k[COEF_W-1]}}, coef_k} *
           {{(PROD_W-PRE_W){pre_add[PRE_W-1]}}, pre_add};
  end

  // Next-state and control
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    x_d          = x_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    acc_d        = acc_q;
    byp_d        = byp_q;
    out_valid_d  = 1'b0;
    out_sample_d = out_sample_q;
    overrun_d    = overrun_q | (in_valid && !in_ready);

    if (coef_we && (int'(coef_addr) < HALF))
      shadow_d[coef_addr] = coef_data;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d[0] = in_sample;
          for (int i = 1; i < TAPS; i++)
            x_d[i] = x_q[i-1];
          // Takes the shadow contents from before any same-cycle write.
          active_d = shadow_q;
          byp_d    = bypass;
          acc_d    = '0;
          k_d      = '0;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{KW{prod[PROD_W-1]}}, prod};
        if (k_q == KW'(HALF - 1))
          state_d = S_ROUND;
        else
          k_d = k_q + KW'(1);
      end
      S_ROUND: begin
        out_valid_d  = 1'b1;
        // In bypass mode, x[0] still holds the accepted sample.
        out_sample_d = byp_q ? x_q[0] : saturate(round_half_up(acc_q));
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      for (int i = 0; i < TAPS; i++)
        x_q[i] <= '0;
      for (int i = 0; i < HALF; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      acc_q        <= '0;
      byp_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      x_q          <= x_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      acc_q        <= acc_d;
      byp_q        <= byp_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule
